// File: rtl/puf_verifier.sv
// puf_verifier: enroll/verify front end for an RO PUF.
// Enroll stores a challenge/response pair per slot; verify re-issues the
// stored challenge and reports the Hamming distance against a threshold.
// Optional feature macro: PUF_VERIFIER_RETRY_EN (one re-measurement on a
// failing verify).
// Handshake: req is taken only while idle and not busy (no queueing);
// puf_start is a level held until puf_done is seen high; result_valid is a
// single-cycle pulse and pass/hd/error hold until the next pulse.
module puf_verifier #(
  parameter int RESP_W  = 256,
  parameter int CHAL_W  = 8,
  parameter int SLOTS   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     enroll,
  input  logic [$clog2(SLOTS)-1:0] slot,
  input  logic [CHAL_W-1:0]        challenge_in,
  input  logic [8:0]               threshold,
  output logic                     busy,
  output logic                     puf_start,
  output logic [CHAL_W-1:0]        puf_challenge,
  input  logic [RESP_W-1:0]        puf_response,
  input  logic                     puf_done,
  output logic                     result_valid,
  output logic                     pass,
  output logic [8:0]               hd,
  output logic                     error,
  output logic [3:0]               dbg_state_o
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int NBYTES = RESP_W / 8;
  localparam int NB_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_COUNT   = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              enroll_q, enroll_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [8:0]        thr_q, thr_d;
  logic              err_q, err_d;
  logic [8:0]        acc_q, acc_d;
  logic [TO_W-1:0]   wcnt_q, wcnt_d;
  logic [NB_W-1:0]   bcnt_q, bcnt_d;
  logic              retry_q, retry_d;
  logic              rv_q, rv_d;
  logic              pass_q, pass_d;
  logic [8:0]        hd_q, hd_d;
  logic              error_q, error_d;
  logic [SLOTS-1:0]  valid_q, valid_d;
  logic [RESP_W-1:0] diff_q, diff_d;
  logic              wr_en;

  logic [CHAL_W-1:0] chal_mem [SLOTS];
  logic [RESP_W-1:0] resp_mem [SLOTS];

  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, b[i]};
    return s;
  endfunction

  // Next-state and datapath decisions for the operation sequencer.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    chal_d   = chal_q;
    enroll_d = enroll_q;
    slot_d   = slot_q;
    thr_d    = thr_q;
    err_d    = err_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    retry_d  = retry_q;
    rv_d     = 1'b0;
    pass_d   = pass_q;
    hd_d     = hd_q;
    error_d  = error_q;
    valid_d  = valid_q;
    diff_d   = diff_q;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rv_q high means the report pulse is still out; stay unavailable.
        if (req && !rv_q) begin
          enroll_d = enroll;
          slot_d   = slot;
          thr_d    = threshold;
          acc_d    = '0;
          err_d    = 1'b0;
          retry_d  = 1'b0;
          if (enroll) begin
            chal_d  = challenge_in;
            state_d = S_ISSUE;
          end else if (!valid_q[slot]) begin
            // Nothing enrolled here: report an error without touching the PUF.
            err_d   = 1'b1;
            state_d = S_REPORT;
          end else begin
            chal_d  = chal_mem[slot];
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A done still high from an earlier run must fall before we start.
        if (!puf_done) begin
          start_d = 1'b1;
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (puf_done) begin
          start_d = 1'b0;
          state_d = S_CAPTURE;
        end else if (wcnt_q == TO_W'(TIMEOUT)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_REPORT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        acc_d = '0;
        if (enroll_q) begin
          wr_en           = 1'b1;
          valid_d[slot_q] = 1'b1;
          state_d         = S_REPORT;
        end else begin
          diff_d  = puf_response ^ resp_mem[slot_q];
          bcnt_d  = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        acc_d  = acc_q + {5'b00000, popcnt8(diff_q[7:0])};
        diff_d = diff_q >> 8;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == NB_W'(NBYTES - 1)) begin
`ifdef PUF_VERIFIER_RETRY_EN
          if (!retry_q && (acc_d > thr_q)) begin
            retry_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_REPORT;
          end
`else
          state_d = S_REPORT;
`endif
        end
      end
      S_REPORT: begin
        rv_d    = 1'b1;
        error_d = err_q;
        hd_d    = err_q ? 9'd0 : acc_q;
        pass_d  = !err_q && (acc_q <= thr_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      chal_q   <= '0;
      enroll_q <= 1'b0;
      slot_q   <= '0;
      thr_q    <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      retry_q  <= 1'b0;
      rv_q     <= 1'b0;
      pass_q   <= 1'b0;
      hd_q     <= '0;
      error_q  <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      chal_q   <= chal_d;
      enroll_q <= enroll_d;
      slot_q   <= slot_d;
      thr_q    <= thr_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      retry_q  <= retry_d;
      rv_q     <= rv_d;
      pass_q   <= pass_d;
      hd_q     <= hd_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
    end
  end

  // Slot contents and the XOR shift register carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      chal_mem[slot_q] <= chal_q;
      resp_mem[slot_q] <= puf_response;
    end
    diff_q <= diff_d;
  end

  assign busy          = (state_q != S_IDLE) || rv_q;
  assign puf_start     = start_q;
  assign puf_challenge = chal_q;
  assign result_valid  = rv_q;
  assign pass          = pass_q;
  assign hd            = hd_q;
  assign error         = error_q;
  assign dbg_state_o   = {retry_q, state_q};

endmodule

// File: tb/tb_puf_verifier.sv
// Directed bench for puf_verifier with a behavioural RO PUF model.
`timescale 1ns/1ps
module tb_puf_verifier;

`ifdef PUF_VERIFIER_RETRY_EN
  localparam int EXP_BIG_HD     = 2;
  localparam int EXP_BIG_PASS   = 1;
  localparam int EXP_FAIL_START = 2;
`else
  localparam int EXP_BIG_HD     = 40;
  localparam int EXP_BIG_PASS   = 0;
  localparam int EXP_FAIL_START = 1;
`endif
  localparam int BUDGET = 3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req, enroll;
  logic [1:0]   slot;
  logic [7:0]   challenge_in;
  logic [8:0]   threshold;
  logic         busy, puf_start, result_valid, pass, error;
  logic [7:0]   puf_challenge;
  logic [255:0] puf_response = '0;
  logic         puf_done = 1'b0;
  logic [8:0]   hd;
  logic [3:0]   dbg_state;

  puf_verifier dut (
    .clk(clk), .rst_n(rst_n), .req(req), .enroll(enroll), .slot(slot),
    .challenge_in(challenge_in), .threshold(threshold), .busy(busy),
    .puf_start(puf_start), .puf_challenge(puf_challenge),
    .puf_response(puf_response), .puf_done(puf_done),
    .result_valid(result_valid), .pass(pass), .hd(hd), .error(error),
    .dbg_state_o(dbg_state)
  );

  // PUF model: mode 0 answers after m_dly start cycles, 1 never answers,
  // 2 holds done high regardless of start.
  int           model_mode = 0;
  int           m_dly = 20;
  int           m_cnt = 0;
  int           start_total = 0;
  int           start_base = 0;
  int           chal_bad = 0;
  logic         start_prev = 1'b0;
  logic [7:0]   exp_chal = 8'h00;
  logic [255:0] resp_a = '0;
  logic [255:0] resp_b = '0;

  always @(negedge clk) begin
    if (puf_start && !start_prev) start_total++;
    start_prev = puf_start;
    if (puf_start && (puf_challenge != exp_chal)) chal_bad++;
    if (model_mode == 2) begin
      puf_done = 1'b1;
    end else if (!puf_start) begin
      m_cnt    = 0;
      puf_done = 1'b0;
    end else if (model_mode == 0 && !puf_done) begin
      m_cnt++;
      if (m_cnt == m_dly) begin
        puf_done     = 1'b1;
        puf_response = (start_total - start_base <= 1) ? resp_a : resp_b;
      end
    end
  end

  // scoreboard counters and checker
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  logic r_pass, r_err;
  logic [8:0] r_hd;
  int   r_lat;

  task automatic send_req(input logic en, input logic [1:0] sl, input logic [7:0] ch,
                          input logic [8:0] th);
    @(negedge clk);
    enroll = en; slot = sl; challenge_in = ch; threshold = th; req = 1'b1;
    start_base = start_total;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Latency counts the req cycle as cycle 0; result_valid seen in cycle n.
  task automatic wait_result();
    int n;
    n = 1;
    while (!result_valid && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    if (!result_valid) begin
      check_eq("wait_rv", 32'(result_valid), 32'd1);
      r_lat = -1;
    end else begin
      r_lat  = n;
      r_pass = pass;
      r_hd   = hd;
      r_err  = error;
      check_eq("busy_rv", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check_eq("rv_pulse", 32'(result_valid), 32'd0);
      check_eq("busy_after", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_op(input logic en, input logic [1:0] sl, input logic [7:0] ch,
                        input logic [8:0] th);
    send_req(en, sl, ch, th);
    wait_result();
  endtask

  logic [255:0] base, v;
  int           highs;

  initial begin
    rst_n = 1'b0; req = 1'b0; enroll = 1'b0; slot = '0; challenge_in = '0; threshold = '0;
    base = {32{8'hA5}};
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(puf_start), 32'd0);
    check_eq("rst_flags", 32'({result_valid, pass, error}), 32'd0);
    check_eq("rst_hd", 32'(hd), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // enroll slot 0
    resp_a = base; exp_chal = 8'h3C;
    run_op(1'b1, 2'd0, 8'h3C, 9'd0);
    check_eq("enr_lat", 32'(r_lat), 32'd24);
    check_eq("enr_pass", 32'(r_pass), 32'd1);
    check_eq("enr_hd", 32'(r_hd), 32'd0);
    check_eq("enr_err", 32'(r_err), 32'd0);
    check_eq("enr_starts", 32'(start_total - start_base), 32'd1);

    // verify, 5 bits flipped; challenge_in must be ignored
    v = base; v[0] = ~v[0]; v[9] = ~v[9]; v[100] = ~v[100]; v[200] = ~v[200]; v[255] = ~v[255];
    resp_a = v;
    run_op(1'b0, 2'd0, 8'h77, 9'd10);
    check_eq("v5_lat", 32'(r_lat), 32'd56);
    check_eq("v5_hd", 32'(r_hd), 32'd5);
    check_eq("v5_pass", 32'(r_pass), 32'd1);
    check_eq("v5_err", 32'(r_err), 32'd0);

    // threshold boundary on the same distance
    resp_b = v;
    run_op(1'b0, 2'd0, 8'h00, 9'd5);
    check_eq("thr_eq_pass", 32'(r_pass), 32'd1);
    run_op(1'b0, 2'd0, 8'h00, 9'd4);
    check_eq("thr_lt_pass", 32'(r_pass), 32'd0);
    check_eq("thr_lt_hd", 32'(r_hd), 32'd5);
    check_eq("thr_lt_starts", 32'(start_total - start_base), 32'(EXP_FAIL_START));

    // verify, 40 bits flipped; second measurement has 2 flips
    v = base; v[39:0] = ~v[39:0]; resp_a = v;
    v = base; v[3] = ~v[3]; v[77] = ~v[77]; resp_b = v;
    run_op(1'b0, 2'd0, 8'h00, 9'd10);
    check_eq("v40_hd", 32'(r_hd), 32'(EXP_BIG_HD));
    check_eq("v40_pass", 32'(r_pass), 32'(EXP_BIG_PASS));
    check_eq("v40_starts", 32'(start_total - start_base), 32'(EXP_FAIL_START));

    // unenrolled slot
    run_op(1'b0, 2'd3, 8'h00, 9'd10);
    check_eq("unen_lat", 32'(r_lat), 32'd2);
    check_eq("unen_err", 32'(r_err), 32'd1);
    check_eq("unen_pass", 32'(r_pass), 32'd0);
    check_eq("unen_hd", 32'(r_hd), 32'd0);
    check_eq("unen_starts", 32'(start_total - start_base), 32'd0);

    // timeout: PUF never answers
    model_mode = 1; exp_chal = 8'h11;
    run_op(1'b1, 2'd1, 8'h11, 9'd0);
    check_eq("to_lat", 32'(r_lat), 32'd1027);
    check_eq("to_err", 32'(r_err), 32'd1);
    check_eq("to_pass", 32'(r_pass), 32'd0);
    check_eq("to_start_low", 32'(puf_start), 32'd0);
    model_mode = 0;
    run_op(1'b0, 2'd1, 8'h00, 9'd10);
    check_eq("to_slot_unen", 32'(r_err), 32'd1);

    // stale done held high before the request
    model_mode = 2; exp_chal = 8'h5A; resp_a = {32{8'h3C}};
    repeat (2) @(negedge clk);
    send_req(1'b1, 2'd2, 8'h5A, 9'd0);
    highs = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (puf_start) highs++;
    end
    check_eq("stale_nostart", 32'(highs), 32'd0);
    check_eq("stale_state", 32'(dbg_state[2:0]), 32'd1);
    model_mode = 0;
    wait_result();
    check_eq("stale_pass", 32'(r_pass), 32'd1);
    check_eq("stale_err", 32'(r_err), 32'd0);
    run_op(1'b0, 2'd2, 8'h00, 9'd0);
    check_eq("slot2_hd", 32'(r_hd), 32'd0);
    check_eq("slot2_pass", 32'(r_pass), 32'd1);

    // full inversion
    resp_a = {32{8'h5A}}; exp_chal = 8'h3C;
    run_op(1'b0, 2'd0, 8'h00, 9'd300);
    check_eq("inv_hd", 32'(r_hd), 32'd256);
    check_eq("inv_pass", 32'(r_pass), 32'd1);
    check_eq("chal_stable", 32'(chal_bad), 32'd0);

    // reset during COUNT
    resp_a = base;
    send_req(1'b0, 2'd0, 8'h00, 9'd10);
    repeat (30) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check_eq("mid_rst_start", 32'(puf_start), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_flags", 32'({result_valid, pass, error}), 32'd0);
    check_eq("mid_rst_hd", 32'(hd), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(1'b0, 2'd0, 8'h00, 9'd10);
    check_eq("post_rst_err", 32'(r_err), 32'd1);
    check_eq("post_rst_lat", 32'(r_lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/puf_verifier.md
# puf_verifier

Authentication front end for the RO PUF. It drives the PUF's `start`/`challenge` inputs and consumes its `response`/`done` outputs. In enroll mode it captures a challenge/response pair into a slot. In verify mode it re-issues the stored challenge and computes the Hamming distance between the fresh response and the stored one, then reports pass/fail against a threshold. It sits between the system controller and the PUF instance.

## Interface
Parameters:
- `RESP_W`, 256: PUF response width; must be a multiple of 8.
- `CHAL_W`, 8: challenge width.
- `SLOTS`, 4: number of enrollment slots; power of two.
- `TIMEOUT`, 1023: maximum cycles to wait for `puf_done`.

Ports:
- `clk`, in, 1: single clock. Everything, including the PUF handshake, is sampled on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: operation request; sampled only in IDLE.
- `enroll`, in, 1: 1 = enroll, 0 = verify; sampled with `req`.
- `slot`, in, log2(SLOTS): slot index; sampled with `req`.
- `challenge_in`, in, CHAL_W: challenge for enroll; ignored in verify.
- `threshold`, in, 9: maximum Hamming distance that still passes; sampled with `req`.
- `busy`, out, 1: an operation is in progress.
- `puf_start`, out, 1: start level to the PUF.
- `puf_challenge`, out, CHAL_W: challenge to the PUF.
- `puf_response`, in, RESP_W: PUF response.
- `puf_done`, in, 1: PUF completion.
- `result_valid`, out, 1: one-cycle completion pulse.
- `pass`, out, 1: verify passed, or enroll succeeded.
- `hd`, out, 9: Hamming distance (0–256); 0 for enroll.
- `error`, out, 1: timeout, or verify on an unenrolled slot.

## Operation
- **Storage:** per slot, a challenge register, a RESP_W response register and a valid bit. All valid bits clear on reset; the data registers are not reset.
- **IDLE:** accepts `req` and latches `enroll`, `slot`, `threshold` and the challenge.
  - Enroll latches the challenge from `challenge_in`.
  - Verify latches the challenge from the slot's stored value.
  - Verify on a slot whose valid bit is 0 goes to REPORT with `error=1`, `pass=0`, `hd=0`. The PUF is not touched.
  - Otherwise the FSM goes to ISSUE.
- **ISSUE:** waits until `puf_done` is 0, so a stale `done` is never accepted. Then it asserts `puf_start` and goes to WAIT.
- **WAIT:** holds `puf_start=1` and `puf_challenge` stable, and counts cycles.
  - When `puf_done` is 1, the FSM drops `puf_start` and goes to CAPTURE.
  - If the count reaches TIMEOUT first, it drops `puf_start` and goes to REPORT with `error=1`.
  - If `puf_done` and the timeout occur in the same cycle, `puf_done` wins.
- **CAPTURE:** latches `puf_response` into the working register.
  - Enroll writes the challenge and response into the slot, sets its valid bit, and goes to REPORT with `pass=1`, `hd=0`.
  - Verify loads `diff = response XOR stored`, clears the accumulator, and goes to COUNT.
- **COUNT:** each cycle adds popcount(`diff[7:0]`) (0–8) to a 9-bit accumulator and shifts `diff` right by 8.
  - This takes RESP_W/8 cycles (32 at the default width).
  - The accumulator cannot overflow because 256 fits in 9 bits.
- **REPORT:** drives `result_valid=1` for one cycle and updates `pass`/`hd`/`error`, then returns to IDLE.
  - `pass = (hd <= threshold) && !error`.
  - If `threshold >= 256`, every non-error verify passes.
- **Held outputs:** `pass`, `hd` and `error` hold their values until the next REPORT.
- **`req` while busy** is ignored; no queueing.
- **Enrolling an already-valid slot** overwrites it.

## Timing
- **Reset values:** all outputs are 0; the FSM is in IDLE.
- **Reset mid-operation:** `puf_start` drops asynchronously, the operation is abandoned with no `result_valid`, and all valid bits clear.
- **`busy`:** goes high the cycle after `req` is accepted and low in the cycle after the `result_valid` pulse.
- **`puf_start`:** rises at most 1 cycle after ISSUE if `puf_done` is low.
- **Enroll latency:** `req` → `result_valid` = 1 (IDLE) + ISSUE + PUF time + 1 (CAPTURE) + 1 (REPORT).
- **Verify latency:** enroll latency + RESP_W/8 COUNT cycles.
- **Unenrolled verify:** `result_valid` 2 cycles after `req`.
- **Timeout:** `result_valid` TIMEOUT+2 cycles after `puf_start` rises.

## Configuration
- **`PUF_VERIFIER_RETRY_EN` defined:**
  - A verify whose `hd > threshold` (no error) re-enters ISSUE once; the second measurement's `hd` and `pass` are reported.
  - An internal retry flag prevents a third attempt.
  - A timeout on the retry reports `error=1`.
- **Not defined:** a single attempt; REPORT follows the first COUNT.

## Test plan
- **Enroll:** reset, then enroll slot 0 with challenge 0x3C; the PUF model returns 0xA5 repeated and `done` after 20 cycles → `pass=1`, `hd=0`, `error=0`; `puf_challenge=0x3C` throughout WAIT.
- **Verify, small distance:** verify slot 0, model returns the enrolled value with 5 bits flipped, `threshold=10` → `hd=5`, `pass=1`; latency is 20 + 32 + overhead as specified.
- **Verify, large distance:** verify slot 0 with 40 flipped bits, `threshold=10` → `hd=40`, `pass=0`.
  - With `PUF_VERIFIER_RETRY_EN` and a second response of 2 flips, expect two `puf_start` pulses and `hd=2`, `pass=1`.
- **Unenrolled slot:** verify slot 3 after reset → `error=1`, `pass=0`, `result_valid` 2 cycles after `req`, `puf_start` never asserted.
- **Timeout and stale `done`:**
  - Model never asserts `done` → `error=1` after TIMEOUT cycles and `puf_start` drops.
  - Model holds `done` high before the request → ISSUE stalls until `done` falls.
- **Full inversion and reset:**
  - All 256 bits differ, `threshold=300` → `hd=256`, `pass=1`.
  - Assert `rst_n` low during COUNT → outputs go to 0 immediately and a subsequent verify of slot 0 reports `error=1`.
